// File: rtl/audio_sample_packet_decoder_if.sv
// Packet input, sample FIFO output and status bundle of the audio decoder.
interface audio_sample_packet_decoder_if;
    logic        packet_valid;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic        audio_valid;
    logic        audio_ready;
    logic [23:0] audio_sample_word [1:0];
    logic [1:0]  valid_bit;
    logic [1:0]  user_data_bit;
    logic [191:0] channel_status_left;
    logic [191:0] channel_status_right;
    logic        channel_status_valid;
    logic        parity_error;
    logic        overflow;

    modport master (
        output packet_valid, header, sub, audio_ready,
        input  audio_valid, audio_sample_word, valid_bit,
        input  user_data_bit, channel_status_left,
        input  channel_status_right, channel_status_valid,
        input  parity_error, overflow
    );

    modport slave (
        input  packet_valid, header, sub, audio_ready,
        output audio_valid, audio_sample_word, valid_bit,
        output user_data_bit, channel_status_left,
        output channel_status_right, channel_status_valid,
        output parity_error, overflow
    );
endinterface

// File: rtl/audio_sample_packet_decoder.sv
// 2-channel audio sample packet unpacker with sample FIFO and channel status.
// Define AUDIO_PARITY_CHECK_EN to build the per-channel parity checker.
module audio_sample_packet_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk_pixel,
    input logic reset_n,
    audio_sample_packet_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [3:0]  present_q, b_q;
    logic [55:0] sub_q [3:0];

    logic        pkt, accept, proc, push;
    logic [55:0] cur;
    logic        c_l, c_r;

    logic [51:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, wr_en;
    logic [51:0]   head;

    logic [7:0]   cs_index;
    logic         cs_sync, cs_pulse;
    logic [191:0] sh_l, sh_r, cs_l, cs_r;

    assign pkt    = bus.packet_valid && bus.header[7:0] == 8'd2
                    && !bus.header[12];
    assign accept = pkt && state == IDLE;
    assign cur    = sub_q[idx];
    assign proc   = state == UNPACK && present_q[idx];
    assign c_l    = cur[50];
    assign c_r    = cur[54];

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pkt) state_nxt = UNPACK;
            UNPACK:  if (idx == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push         = proc;
        bus.overflow = (state == UNPACK && pkt)
                       || (proc && full && !pop);
    end

`ifdef AUDIO_PARITY_CHECK_EN
    logic par_l, par_r;
    assign par_l = cur[51] != ^{cur[50:48], cur[23:0]};
    assign par_r = cur[55] != ^{cur[54:52], cur[47:24]};
    assign bus.parity_error = proc && (par_l || par_r);
`else
    assign bus.parity_error = 1'b0;
`endif

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            present_q <= '0;
            b_q       <= '0;
            for (int k = 0; k < 4; k++) sub_q[k] <= '0;
        end else if (accept) begin
            idx       <= '0;
            present_q <= bus.header[11:8];
            b_q       <= bus.header[19:16];
            sub_q     <= bus.sub;
        end else if (state == UNPACK) begin
            idx <= idx + 2'd1;
        end
    end

    // A pop frees the full slot in the same cycle, so push still lands.
    assign empty = count == '0;
    assign full  = count == FULL_CNT;
    assign pop   = !empty && bus.audio_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_pixel) begin
        if (wr_en)
            mem[wr_ptr] <= {cur[47:24], cur[23:0],
                            cur[53], cur[49], cur[52], cur[48]};
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        bus.audio_valid          = !empty;
        bus.audio_sample_word[0] = empty ? '0 : head[27:4];
        bus.audio_sample_word[1] = empty ? '0 : head[51:28];
        bus.user_data_bit        = empty ? '0 : head[3:2];
        bus.valid_bit            = empty ? '0 : head[1:0];
    end

    // A block start (B=1) always restarts collection at frame 0.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cs_index <= '0;
            cs_sync  <= 1'b0;
            cs_pulse <= 1'b0;
            sh_l     <= '0;
            sh_r     <= '0;
            cs_l     <= '0;
            cs_r     <= '0;
        end else begin
            cs_pulse <= 1'b0;
            if (proc && b_q[idx]) begin
                sh_l[0]  <= c_l;
                sh_r[0]  <= c_r;
                cs_index <= 8'd1;
                cs_sync  <= 1'b1;
            end else if (proc && cs_sync) begin
                sh_l[cs_index] <= c_l;
                sh_r[cs_index] <= c_r;
                cs_index       <= cs_index + 8'd1;
                if (cs_index == 8'd191) begin
                    cs_l     <= {c_l, sh_l[190:0]};
                    cs_r     <= {c_r, sh_r[190:0]};
                    cs_pulse <= 1'b1;
                    cs_sync  <= 1'b0;
                end
            end
        end
    end

    assign bus.channel_status_left  = cs_l;
    assign bus.channel_status_right = cs_r;
    assign bus.channel_status_valid = cs_pulse;
endmodule
